// File: rtl/prio_pkg.sv
// Shared types for the N-way priority / round-robin arbiter.
package prio_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/prio_find_msb.sv
// Finds the first set bit of i_vec searching downward from i_start,
// wrapping from 0 back to N-1 (modulo N, not 2^IW).
module prio_find_msb
    import prio_pkg::*;
#(
    parameter  int N  = 8,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_vec,
    input  logic [IW-1:0] i_start,
    output logic          o_found,
    output logic [IW-1:0] o_idx
);

    always_comb begin
        int p;
        o_found = 1'b0;
        o_idx   = '0;
        p       = 0;
        for (int k = 0; k < N; k++) begin
            p = int'(i_start) - k;
            if (p < 0) begin
                p = p + N;
            end
            if (!o_found && i_vec[p[IW-1:0]]) begin
                o_found = 1'b1;
                o_idx   = p[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/prio_arbiter.sv
// N-way arbiter, fixed or round-robin, with registered one-hot/binary
// grant held until accepted over a valid/ready handshake.
module prio_arbiter
    import prio_pkg::*;
#(
    parameter  int N  = 8,
    localparam int IW = $clog2(N)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_mode,
    input  logic [N-1:0]  i_req,
    output logic          o_gnt_valid,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_gnt_idx,
    input  logic          i_gnt_ready
);

    localparam logic [IW-1:0] LP_TOP = IW'(N - 1);
    localparam logic [N-1:0]  LP_ONE = {{(N-1){1'b0}}, 1'b1};

    arb_state_e    r_state;
    arb_mode_e     r_mode_q;
    logic [IW-1:0] r_last;
    logic [IW-1:0] r_gnt_idx;
    logic [N-1:0]  r_gnt;
    logic          r_gnt_valid;

    logic          w_idle;
    arb_mode_e     w_mode;
    logic [IW-1:0] w_last;
    logic [IW-1:0] w_start;
    logic          w_found;
    logic [IW-1:0] w_idx;

    // A back-to-back winner searches relative to the index being accepted.
    always_comb begin
        w_idle  = (r_state == ST_IDLE);
        w_mode  = w_idle ? arb_mode_e'(i_mode) : r_mode_q;
        w_last  = w_idle ? r_last : r_gnt_idx;
        w_start = LP_TOP;
        if (w_mode == ARB_RR && w_last != '0) begin
            w_start = w_last - IW'(1);
        end
    end

    prio_find_msb #(
        .N(N)
    ) u_find (
        .i_vec   (i_req),
        .i_start (w_start),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_mode_q    <= ARB_FIXED;
            r_last      <= '0;
            r_gnt_idx   <= '0;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_mode_q <= arb_mode_e'(i_mode);
                    if (w_found) begin
                        r_state     <= ST_GRANT;
                        r_gnt_valid <= 1'b1;
                        r_gnt       <= LP_ONE << w_idx;
                        r_gnt_idx   <= w_idx;
                    end
                end
                ST_GRANT: begin
                    if (i_gnt_ready) begin
                        r_last <= r_gnt_idx;
                        if (w_found) begin
                            r_gnt     <= LP_ONE << w_idx;
                            r_gnt_idx <= w_idx;
                        end else begin
                            r_state     <= ST_IDLE;
                            r_gnt_valid <= 1'b0;
                            r_gnt       <= '0;
                            r_gnt_idx   <= '0;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_gnt_valid = r_gnt_valid;
    assign o_gnt       = r_gnt;
    assign o_gnt_idx   = r_gnt_idx;

endmodule

// File: tb/tb_prio_arbiter.sv
// Scoreboard bench for prio_arbiter at N=8 and N=5 sharing one stimulus
// stream; a distance-based reference model predicts every cycle's outputs.
module tb_prio_arbiter;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       mode = 1'b0;
    logic       rdy  = 1'b0;
    logic [7:0] req8 = '0;
    logic [4:0] req5 = '0;

    logic       o8_v;
    logic [7:0] o8_gnt;
    logic [2:0] o8_idx;
    logic       o5_v;
    logic [4:0] o5_gnt;
    logic [2:0] o5_idx;

    always #5 clk = ~clk;

    prio_arbiter #(.N(8)) u8 (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_mode      (mode),
        .i_req       (req8),
        .o_gnt_valid (o8_v),
        .o_gnt       (o8_gnt),
        .o_gnt_idx   (o8_idx),
        .i_gnt_ready (rdy)
    );

    prio_arbiter #(.N(5)) u5 (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_mode      (mode),
        .i_req       (req5),
        .o_gnt_valid (o5_v),
        .o_gnt       (o5_gnt),
        .o_gnt_idx   (o5_idx),
        .i_gnt_ready (rdy)
    );

    typedef struct {
        bit v;
        int idx;
    } exp_t;

    exp_t q8[$];
    exp_t q5[$];
    int   total = 0;
    int   bad   = 0;

    int mn[2] = '{8, 5};
    bit mv[2];
    int mi[2];
    int ml[2];
    bit mm[2];

    // Pick the requester closest below 'last' (cyclically) in RR,
    // or the highest index in fixed mode.
    function automatic int winner(logic [63:0] r, int n, bit rr, int last);
        int best  = -1;
        int bestd = n + 1;
        int d;
        for (int i = 0; i < n; i++) begin
            if (r[i]) begin
                d = rr ? ((last - 1 - i + 2 * n) % n) : (n - 1 - i);
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    task automatic model_step(input int u, input logic [63:0] r,
                              input bit rd, input bit md,
                              output exp_t e);
        if (!mv[u]) begin
            mm[u] = md;
            if (r != 0) begin
                mi[u] = winner(r, mn[u], md, ml[u]);
                mv[u] = 1'b1;
            end
        end else if (rd) begin
            ml[u] = mi[u];
            if (r != 0) begin
                mi[u] = winner(r, mn[u], mm[u], ml[u]);
            end else begin
                mv[u] = 1'b0;
            end
        end
        e.v   = mv[u];
        e.idx = mv[u] ? mi[u] : 0;
    endtask

    task automatic check(input string nm, input logic v,
                         input logic [31:0] idx, input logic [63:0] g,
                         input exp_t e);
        logic [63:0] eg;
        logic [31:0] ei;
        eg = e.v ? (64'd1 << e.idx) : 64'd0;
        ei = e.v ? 32'(e.idx) : 32'd0;
        total++;
        if (v !== e.v || idx !== ei || g !== eg) begin
            bad++;
            $display("FAIL %s t=%0t: got v=%0b idx=%0d gnt=%h, want v=%0b idx=%0d gnt=%h",
                     nm, $time, v, idx, g, e.v, ei, eg);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q8.size() != 0) begin
                e = q8.pop_front();
                check("n8_out", o8_v, 32'(o8_idx), 64'(o8_gnt), e);
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q5.size() != 0) begin
                e = q5.pop_front();
                check("n5_out", o5_v, 32'(o5_idx), 64'(o5_gnt), e);
            end
        end
    end

    task automatic step(input logic [7:0] r8, input logic [4:0] r5,
                        input bit rd, input bit md, input bit rs);
        exp_t e;
        exp_t z;
        z.v   = 1'b0;
        z.idx = 0;
        @(posedge clk);
        #2;
        req8 = r8;
        req5 = r5;
        rdy  = rd;
        mode = md;
        rst  = rs;
        if (rs) begin
            for (int u = 0; u < 2; u++) begin
                mv[u] = 1'b0;
                mi[u] = 0;
                ml[u] = 0;
                mm[u] = 1'b0;
            end
            q8.push_back(z);
            q5.push_back(z);
            #1;
            check("rst_async8", o8_v, 32'(o8_idx), 64'(o8_gnt), z);
            check("rst_async5", o5_v, 32'(o5_idx), 64'(o5_gnt), z);
        end else begin
            model_step(0, 64'(r8), rd, md, e);
            q8.push_back(e);
            model_step(1, 64'(r5), rd, md, e);
            q5.push_back(e);
        end
    endtask

    initial begin
        logic [7:0] r8;
        logic [4:0] r5;
        bit         rd;
        bit         md;
        bit         rs;

        repeat (2) step(8'h00, 5'h00, 1'b0, 1'b0, 1'b1);

        // idle with no requests
        repeat (5) step(8'h00, 5'h00, 1'b1, 1'b0, 1'b0);

        // fixed priority, dropping the top requester twice
        repeat (3) step(8'h29, 5'h11, 1'b1, 1'b0, 1'b0);
        repeat (2) step(8'h09, 5'h11, 1'b1, 1'b0, 1'b0);
        repeat (2) step(8'h01, 5'h11, 1'b1, 1'b0, 1'b0);
        repeat (2) step(8'h00, 5'h00, 1'b1, 1'b0, 1'b0);

        // round-robin with every requester active
        repeat (10) step(8'hFF, 5'h11, 1'b1, 1'b1, 1'b0);
        repeat (2) step(8'h00, 5'h00, 1'b1, 1'b1, 1'b0);

        // round-robin with a stalled consumer
        repeat (4) step(8'h82, 5'h11, 1'b0, 1'b1, 1'b0);
        repeat (3) step(8'h82, 5'h11, 1'b1, 1'b1, 1'b0);
        repeat (2) step(8'h00, 5'h00, 1'b1, 1'b1, 1'b0);

        // held grant survives req drop and mode flip
        step(8'h10, 5'h00, 1'b0, 1'b0, 1'b0);
        repeat (2) step(8'h0C, 5'h00, 1'b0, 1'b1, 1'b0);
        repeat (2) step(8'h0C, 5'h00, 1'b1, 1'b1, 1'b0);
        step(8'h00, 5'h00, 1'b1, 1'b1, 1'b0);
        repeat (2) step(8'h0C, 5'h00, 1'b1, 1'b1, 1'b0);
        step(8'h00, 5'h00, 1'b1, 1'b1, 1'b0);

        // reset mid-grant, then N=5 wrap
        repeat (2) step(8'hF0, 5'h11, 1'b0, 1'b1, 1'b0);
        step(8'hF0, 5'h11, 1'b0, 1'b1, 1'b1);
        repeat (5) step(8'hF0, 5'h11, 1'b1, 1'b1, 1'b0);
        repeat (2) step(8'h00, 5'h00, 1'b1, 1'b0, 1'b0);

        repeat (3000) begin
            r8 = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            r5 = ($urandom_range(0, 3) == 0) ? 5'h00 : 5'($urandom);
            rd = ($urandom_range(0, 3) != 0);
            md = 1'($urandom_range(0, 1));
            rs = ($urandom_range(0, 199) == 0);
            step(r8, r5, rd, md, rs);
        end

        repeat (3) step(8'h00, 5'h00, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        total++;
        if (q8.size() != 0) begin
            bad++;
            $display("FAIL q8_drain: got %0d left, want 0", q8.size());
        end
        total++;
        if (q5.size() != 0) begin
            bad++;
            $display("FAIL q5_drain: got %0d left, want 0", q5.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
